// File: rtl/key_expansion_seq.sv
// key_expansion_seq
//   Iterative AES-128 key schedule. Expands a 128-bit cipher key into the
//   44-word schedule used by the cipher datapath, one 32-bit word per clock.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      request expansion of key (accepted in IDLE or DONE only)
//   key        cipher key [0:127], bit 0 = MSB of byte 0; sampled on the accepted start edge
//   words      schedule [0:1407], word i at [32*i +: 32], round key r at [128*r +: 128]
//   busy       high while words 4..43 are being computed
//   key_valid  high once all 44 words are final; held until next start or rst
//   word_idx   index of the next word to be computed (debug)
module key_expansion_seq #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [0:32*NK-1]           key,
    output logic [0:32*NK*(NR+1)-1]    words,
    output logic                       busy,
    output logic                       key_valid,
    output logic [5:0]                 word_idx
);

    localparam int NWORDS = NK * (NR + 1);
    localparam int WBITS  = 32 * NWORDS;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Round constant indexed by i/4, i.e. word_idx[5:2].
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [0:WBITS-1]    words_q, words_d;
    logic                busy_q, busy_d;
    logic                key_valid_q, key_valid_d;
    logic [5:0]          word_idx_q, word_idx_d;

    int unsigned         widx;
    logic [31:0]         prev_w;
    logic [31:0]         back_w;
    logic [31:0]         rot_w;
    logic [31:0]         temp_w;
    logic [31:0]         new_w;

    // Datapath for the word at word_idx. The index is clamped into 4..43 so
    // the part-selects stay in range when the FSM is not expanding.
    always_comb begin
        widx = 32'd4;
        if (word_idx_q >= 6'd4 && word_idx_q < 6'(NWORDS)) begin
            widx = 32'(word_idx_q);
        end
        prev_w = words_q[32*(widx-1) +: 32];
        back_w = words_q[32*(widx-4) +: 32];
        rot_w  = {prev_w[23:0], prev_w[31:24]};
        temp_w = prev_w;
        if (word_idx_q[1:0] == 2'b00) begin
            temp_w = sub_word(rot_w) ^ {rcon(word_idx_q[5:2]), 24'h0};
        end
        new_w = back_w ^ temp_w;
    end

    always_comb begin
        state_d     = state_q;
        words_d     = words_q;
        busy_d      = busy_q;
        key_valid_d = key_valid_q;
        word_idx_d  = word_idx_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    words_d           = '0;
                    words_d[0 +: 128] = key;
                    word_idx_d        = 6'd4;
                    busy_d            = 1'b1;
                    key_valid_d       = 1'b0;
                    state_d           = EXPAND;
                end
            end
            EXPAND: begin
                words_d[32*widx +: 32] = new_w;
                word_idx_d             = word_idx_q + 6'd1;
                if (word_idx_q == 6'(NWORDS - 1)) begin
                    busy_d      = 1'b0;
                    key_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            words_q     <= '0;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
            word_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            busy_q      <= busy_d;
            key_valid_q <= key_valid_d;
            word_idx_q  <= word_idx_d;
        end
    end

    assign words     = words_q;
    assign busy      = busy_q;
    assign key_valid = key_valid_q;
    assign word_idx  = word_idx_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Self-checking bench for key_expansion_seq. The reference schedule is built
// from the AES definitions: S-box from GF(2^8) inversion plus affine map,
// Rcon by repeated doubling.
module tb_key_expansion_seq;

    logic            clk;
    logic            rst;
    logic            start;
    logic [0:127]    key;
    logic [0:1407]   words;
    logic            busy;
    logic            key_valid;
    logic [5:0]      word_idx;

    int tests;
    int failed;

    logic [7:0] sb [256];

    key_expansion_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .words     (words),
        .busy      (busy),
        .key_valid (key_valid),
        .word_idx  (word_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:1407] ref_schedule(input logic [0:127] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1407] out;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) out[32*i +: 32] = w[i];
        return out;
    endfunction

    task automatic chk(input string tag, input logic [1407:0] obs, input logic [1407:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:127] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accepts a start with key k and follows the expansion to completion.
    // With inject set, a second start carrying k2 is driven at EXPAND cycle 20.
    task automatic expand(input logic [0:127] k, input bit inject, input logic [0:127] k2);
        logic [0:1407] exp_w;
        int n;
        int busy_n;
        exp_w = ref_schedule(k);
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_key_valid", key_valid, 0);
        chk("load_busy", busy, 1);
        chk("load_word_idx", word_idx, 4);
        chk("load_key", words[0 +: 128], k);
        chk("load_clear", words[128 +: 1280], 0);
        n      = 0;
        busy_n = 1;
        while (!key_valid && n < 60) begin
            if (inject && n == 20) begin
                start = 1'b1;
                key   = k2;
            end else begin
                key = rand_key();
            end
            tick();
            start = 1'b0;
            n++;
            if (busy) busy_n++;
            if (!key_valid) chk("word_idx_step", word_idx, 4 + n);
        end
        chk("latency", n, 40);
        chk("busy_cycles", busy_n, 40);
        chk("final_busy", busy, 0);
        chk("final_word_idx", word_idx, 44);
        chk("schedule", words, exp_w);
    endtask

    initial begin
        logic [0:127]  k;
        logic [0:1407] held;
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        key    = '0;
        build_sbox();

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_words", words, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_word_idx", word_idx, 0);
        tick();
        chk("idle_word_idx", word_idx, 0);

        // FIPS-197 example key
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expand(k, 1'b0, '0);
        chk("fips_rk1", words[128 +: 128], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_rk10", words[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_rk0", words[0 +: 128], k);

        // Held in DONE while key wiggles
        held = words;
        for (int i = 0; i < 5; i++) begin
            key = rand_key();
            tick();
        end
        chk("done_hold", words, held);
        chk("done_key_valid", key_valid, 1);

        // All-zero key
        expand('0, 1'b0, '0);
        chk("zero_rk1", words[128 +: 128], 128'h62636363626363636263636362636363);
        chk("zero_w43", words[32*43 +: 32], 32'h6f8f188e);
        chk("zero_rk10", words[1280 +: 128], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Start during EXPAND is ignored
        expand(rand_key(), 1'b1, rand_key());

        // Reset together with start mid-expansion
        key   = rand_key();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        rst   = 1'b1;
        start = 1'b1;
        key   = rand_key();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("midrst_words", words, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_key_valid", key_valid, 0);
        chk("midrst_word_idx", word_idx, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("midrst_idle_key_valid", key_valid, 0);
        chk("midrst_idle_word_idx", word_idx, 0);
        expand(rand_key(), 1'b0, '0);

        // Restart from DONE
        k = 128'h000102030405060708090a0b0c0d0e0f;
        expand(k, 1'b0, '0);
        chk("restart_rk10", words[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Random keys
        for (int r = 0; r < 4; r++) expand(rand_key(), 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
